// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Data-port bundle between the RISC-V core (master) and its data memory
// responder (slave).
//   req    core -> mem  access request (MemStrobe), held until ready=1
//   we     core -> mem  write request (MemWrite)
//   size   core -> mem  00 word, 01 half, 10 byte, 11 word
//   addr   core -> mem  byte address
//   wdata  core -> mem  lane-positioned write data
//   rdata  mem -> core  full 32-bit word at addr[31:2]
//   ready  mem -> core  access complete (PCReady)
//   err    mem -> core  misaligned / out-of-range, valid with ready & req
// -----------------------------------------------------------------------------
interface dmem_responder_if;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        err;

   modport master (
      output req, we, size, addr, wdata,
      input  rdata, ready, err
   );

   modport slave (
      input  req, we, size, addr, wdata,
      output rdata, ready, err
   );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Memory-side responder for the core's data port. Serves word-addressed RAM
// accesses after LATENCY wait cycles and holds PCReady (bus.ready) low while
// an access is in flight.
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    dmem_responder_if.slave (req/we/size/addr/wdata in,
//          rdata/ready/err out)
// Parameters:
//   DEPTH    number of 32-bit words (>= 2), word index = addr[31:2]
//   LATENCY  wait cycles before completion, 0 = single-cycle memory
//   CNT_W    wait counter width, LATENCY must be < 2**CNT_W
// RAM contents are not cleared by reset; a wrapper or bench preloads them.
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter int DEPTH   = 2048,
   parameter int LATENCY = 2,
   parameter int CNT_W   = 4
) (
   input  logic             clk,
   input  logic             reset,
   dmem_responder_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;

   // Value loaded on entry to BUSY: number of BUSY cycles remaining.
   localparam int             CNT_INIT_I = (LATENCY > 0) ? LATENCY - 1 : 0;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_INIT_I[CNT_W-1:0];

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [31:0]      ram [DEPTH];
   logic [31:0]      ram_rdata_q;   // registered (block RAM) read port
   logic [31:0]      rd_word;
   logic [AW-1:0]    ram_idx;
   logic [29:0]      word_addr;
   logic             in_range;
   logic             misaligned;
   logic             err_c;
   logic [3:0]       strb;
   logic [3:0]       byte_we;
   logic             acc_phase;
   logic             wr_en;

   // -------------------------------------------------------------------------
   // Address decode, error detection and byte strobes
   // -------------------------------------------------------------------------
   assign word_addr = bus.addr[31:2];
   assign ram_idx   = bus.addr[AW+1:2];
   assign in_range  = (word_addr < 30'(DEPTH));

   always_comb begin
      misaligned = 1'b0;
      strb       = 4'b1111;
      case (bus.size)
         SZ_HALF: begin
            misaligned = bus.addr[0];
            strb       = bus.addr[1] ? 4'b1100 : 4'b0011;
         end
         SZ_BYTE: begin
            misaligned = 1'b0;
            strb       = 4'b0001 << bus.addr[1:0];
         end
         default: begin
            // SZ_WORD and the unused 11 encoding both behave as word
            misaligned = (bus.addr[1:0] != 2'b00);
            strb       = 4'b1111;
         end
      endcase
   end

   assign err_c = misaligned | ~in_range;

   // -------------------------------------------------------------------------
   // Access FSM. cnt counts the BUSY cycles still to go; the FSM leaves BUSY
   // as it reaches zero so that the IDLE request cycle plus BUSY adds up to
   // LATENCY stall cycles, then one DONE cycle.
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (LATENCY != 0) begin
         case (state_q)
            ST_IDLE: begin
               if (bus.req) begin
                  if (CNT_INIT == '0) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_BUSY;
                     cnt_d   = CNT_INIT;
                  end
               end
            end
            ST_BUSY: begin
               if (!bus.req) begin
                  // core withdrew the request: abort, nothing is written
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) begin
                     state_d = ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // -------------------------------------------------------------------------
   // Completion phase: always for the zero-wait memory, DONE otherwise.
   // Gating with reset keeps outputs quiet and blocks writes during reset.
   // -------------------------------------------------------------------------
   assign acc_phase = reset & ((LATENCY == 0) ? 1'b1 : (state_q == ST_DONE));
   assign wr_en     = acc_phase & bus.req & bus.we & ~err_c;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign byte_we[gi] = wr_en & strb[gi];
      end
   endgenerate

   // -------------------------------------------------------------------------
   // RAM: byte-lane write, registered read. The read register samples every
   // cycle, so a read following a write sees the committed data.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (byte_we[b]) begin
            ram[ram_idx][b*8 +: 8] <= bus.wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      ram_rdata_q <= ram[ram_idx];
   end

   // Zero-wait memory has to answer in the same cycle, so it reads through.
   assign rd_word = (LATENCY == 0) ? ram[ram_idx] : ram_rdata_q;

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   always_comb begin
      bus.ready = 1'b0;
      if (reset) begin
         if (LATENCY == 0) begin
            bus.ready = 1'b1;
         end else begin
            case (state_q)
               ST_IDLE: bus.ready = ~bus.req;  // non-memory instructions never stall
               ST_BUSY: bus.ready = 1'b0;
               ST_DONE: bus.ready = 1'b1;
               default: bus.ready = 1'b0;
            endcase
         end
      end
   end

   assign bus.err   = acc_phase & bus.req & err_c;
   assign bus.rdata = (acc_phase && !err_c) ? rd_word : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_err;

    dmem_responder_if b0();
    dmem_responder_if b2();
    dmem_responder_if b3();

    dmem_responder #(.DEPTH(2048), .LATENCY(0), .CNT_W(4)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
    dmem_responder #(.DEPTH(2048), .LATENCY(2), .CNT_W(4)) dut2 (.clk(clk), .reset(reset), .bus(b2.slave));
    dmem_responder #(.DEPTH(2048), .LATENCY(3), .CNT_W(4)) dut3 (.clk(clk), .reset(reset), .bus(b3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    // One access on the LATENCY=2 instance; leaves req asserted after the pulse.
    task automatic acc2(input logic we_i, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int waits, output logic done);
        @(posedge clk); #1;
        b2.req = 1'b1; b2.we = we_i; b2.size = sz; b2.addr = a; b2.wdata = wd;
        waits = 0; done = 1'b0; rd = '0; er = 1'b0;
        for (int i = 0; i < 16 && !done; i++) begin
            @(negedge clk);
            if (b2.ready === 1'b1) begin
                done = 1'b1; rd = b2.rdata; er = b2.err;
            end else begin
                waits++;
            end
        end
    endtask

    task automatic idle2();
        @(posedge clk); #1;
        b2.req = 1'b0; b2.we = 1'b0;
    endtask

    // Same for the LATENCY=3 instance, also returning the cycle of the pulse.
    task automatic acc3(input logic we_i, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int waits, output logic done, output int stamp);
        @(posedge clk); #1;
        b3.req = 1'b1; b3.we = we_i; b3.size = sz; b3.addr = a; b3.wdata = wd;
        waits = 0; done = 1'b0; rd = '0; er = 1'b0; stamp = 0;
        for (int i = 0; i < 16 && !done; i++) begin
            @(negedge clk);
            if (b3.ready === 1'b1) begin
                done = 1'b1; rd = b3.rdata; er = b3.err; stamp = cyc;
            end else begin
                waits++;
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        done;
        int          waits;
        int          t1, t2, t3;

        n_checks = 0; n_err = 0; cyc = 0;
        reset = 1'b0;
        b0.req = 0; b0.we = 0; b0.size = 0; b0.addr = 0; b0.wdata = 0;
        b2.req = 0; b2.we = 0; b2.size = 0; b2.addr = 0; b2.wdata = 0;
        b3.req = 0; b3.we = 0; b3.size = 0; b3.addr = 0; b3.wdata = 0;

        //            we    size   addr          wdata         chk   exp_rdata     err
        vecs[0]  = '{1'b1, 2'b00, 32'h0000_0064, 32'h0000_0019, 1'b0, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 2'b00, 32'h0000_0064, 32'h0,         1'b1, 32'h0000_0019, 1'b0};
        vecs[2]  = '{1'b1, 2'b00, 32'h0000_0064, 32'h1122_3344, 1'b0, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 2'b10, 32'h0000_0065, 32'h0000_AB00, 1'b0, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 2'b00, 32'h0000_0064, 32'h0,         1'b1, 32'h1122_AB44, 1'b0};
        vecs[5]  = '{1'b1, 2'b01, 32'h0000_0066, 32'hBEEF_0000, 1'b0, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 2'b00, 32'h0000_0064, 32'h0,         1'b1, 32'hBEEF_AB44, 1'b0};
        vecs[7]  = '{1'b1, 2'b01, 32'h0000_0063, 32'hFFFF_FFFF, 1'b1, 32'h0,        1'b1};
        vecs[8]  = '{1'b1, 2'b00, 32'h0000_0066, 32'h1234_5678, 1'b1, 32'h0,        1'b1};
        vecs[9]  = '{1'b0, 2'b00, 32'h0000_0064, 32'h0,         1'b1, 32'hBEEF_AB44, 1'b0};
        vecs[10] = '{1'b0, 2'b00, 32'h0000_2000, 32'h0,         1'b1, 32'h0,        1'b1};
        vecs[11] = '{1'b0, 2'b10, 32'h0000_0067, 32'h0,         1'b1, 32'hBEEF_AB44, 1'b0};
        vecs[12] = '{1'b0, 2'b01, 32'h0000_0065, 32'h0,         1'b1, 32'h0,        1'b1};
        vecs[13] = '{1'b1, 2'b00, 32'h0000_1FFC, 32'hCAFE_F00D, 1'b0, 32'h0,        1'b0};
        vecs[14] = '{1'b0, 2'b00, 32'h0000_1FFC, 32'h0,         1'b1, 32'hCAFE_F00D, 1'b0};
        vecs[15] = '{1'b0, 2'b11, 32'h0000_1FFE, 32'h0,         1'b1, 32'h0,        1'b1};
        vecs[16] = '{1'b1, 2'b10, 32'h0000_1FFF, 32'h5A00_0000, 1'b0, 32'h0,        1'b0};
        vecs[17] = '{1'b0, 2'b11, 32'h0000_1FFC, 32'h0,         1'b1, 32'h5AFE_F00D, 1'b0};
        vecs[18] = '{1'b1, 2'b00, 32'h0000_2004, 32'h7777_7777, 1'b1, 32'h0,        1'b1};

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_ready_l0", {31'b0, b0.ready}, 32'h0);
        check("rst_ready_l2", {31'b0, b2.ready}, 32'h0);
        check("rst_ready_l3", {31'b0, b3.ready}, 32'h0);
        check("rst_rdata_l0", b0.rdata, 32'h0);
        check("rst_err_l2",   {31'b0, b2.err}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("idle_ready_l2", {31'b0, b2.ready}, 32'h1);
        check("idle_ready_l0", {31'b0, b0.ready}, 32'h1);

        // ---------------- LATENCY=2 table ----------------
        for (int i = 0; i < NV; i++) begin
            acc2(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, rd, er, waits, done);
            check($sformatf("v%0d_done", i), {31'b0, done}, 32'h1);
            check($sformatf("v%0d_waits", i), waits, 32'd2);
            check($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            idle2();
        end

        // ---------------- reset in BUSY drops the pending store ----------------
        @(posedge clk); #1;
        b2.req = 1'b1; b2.we = 1'b1; b2.size = 2'b00; b2.addr = 32'h64; b2.wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rstmid_idle_ready", {31'b0, b2.ready}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("rstmid_ready", {31'b0, b2.ready}, 32'h0);
        check("rstmid_state", {30'b0, dut2.state_q}, 32'h0);
        @(negedge clk);
        check("rstmid_ready_hold", {31'b0, b2.ready}, 32'h0);
        check("rstmid_rdata", b2.rdata, 32'h0);
        @(posedge clk); #1;
        b2.req = 1'b0; b2.we = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("rstmid_release_ready", {31'b0, b2.ready}, 32'h1);
        acc2(1'b0, 2'b00, 32'h64, 32'h0, rd, er, waits, done);
        check("rstmid_ram_kept", rd, 32'hBEEF_AB44);
        idle2();

        // ---------------- LATENCY=0 store then load ----------------
        @(posedge clk); #1;
        b0.req = 1'b1; b0.we = 1'b1; b0.size = 2'b00; b0.addr = 32'd100; b0.wdata = 32'd25;
        @(negedge clk);
        check("l0_sw_ready", {31'b0, b0.ready}, 32'h1);
        check("l0_sw_err", {31'b0, b0.err}, 32'h0);
        @(posedge clk); #1;
        b0.we = 1'b0;
        @(negedge clk);
        check("l0_lw_ready", {31'b0, b0.ready}, 32'h1);
        check("l0_lw_rdata", b0.rdata, 32'h0000_0019);
        @(posedge clk); #1;
        b0.we = 1'b1; b0.size = 2'b10; b0.addr = 32'd101; b0.wdata = 32'h0000_7700;
        @(negedge clk);
        check("l0_sb_ready", {31'b0, b0.ready}, 32'h1);
        @(posedge clk); #1;
        b0.we = 1'b0; b0.size = 2'b00; b0.addr = 32'd100;
        @(negedge clk);
        check("l0_lw2_rdata", b0.rdata, 32'h0000_7719);
        @(posedge clk); #1;
        b0.we = 1'b1; b0.size = 2'b00; b0.addr = 32'h66; b0.wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("l0_mis_err", {31'b0, b0.err}, 32'h1);
        check("l0_mis_rdata", b0.rdata, 32'h0);
        check("l0_mis_ready", {31'b0, b0.ready}, 32'h1);
        @(posedge clk); #1;
        b0.we = 1'b0; b0.addr = 32'h64;
        @(negedge clk);
        check("l0_mis_nowrite", b0.rdata, 32'h0000_7719);
        @(posedge clk); #1;
        b0.req = 1'b0;
        @(negedge clk);
        check("l0_noreq_ready", {31'b0, b0.ready}, 32'h1);

        // ---------------- LATENCY=3 abort and back-to-back ----------------
        acc3(1'b1, 2'b00, 32'h40, 32'h0101_0101, rd, er, waits, done, t1);
        check("l3_sw_waits", waits, 32'd3);
        @(posedge clk); #1;
        b3.req = 1'b0; b3.we = 1'b0;
        @(posedge clk); #1;
        b3.req = 1'b1; b3.we = 1'b1; b3.size = 2'b00; b3.addr = 32'h40; b3.wdata = 32'h7777_7777;
        @(negedge clk);
        check("l3_abort_idle_ready", {31'b0, b3.ready}, 32'h0);
        @(posedge clk); #1;
        b3.req = 1'b0; b3.we = 1'b0;
        @(negedge clk);
        check("l3_abort_busy_ready", {31'b0, b3.ready}, 32'h0);
        @(negedge clk);
        check("l3_abort_ready", {31'b0, b3.ready}, 32'h1);
        check("l3_abort_state", {30'b0, dut3.state_q}, 32'h0);

        acc3(1'b1, 2'b00, 32'h80, 32'h0BAD_CAFE, rd, er, waits, done, t1);
        check("b2b_sw_done", {31'b0, done}, 32'h1);
        acc3(1'b0, 2'b00, 32'h80, 32'h0, rd, er, waits, done, t2);
        check("b2b_raw_rdata", rd, 32'h0BAD_CAFE);
        check("b2b_gap1", t2 - t1, 32'd4);
        acc3(1'b0, 2'b00, 32'h40, 32'h0, rd, er, waits, done, t3);
        check("b2b_abort_kept", rd, 32'h0101_0101);
        check("b2b_gap2", t3 - t2, 32'd4);
        check("b2b_waits", waits, 32'd3);
        @(posedge clk); #1;
        b3.req = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the single-cycle RISC-V core's data port.
- Accepts the core's data request (strobe, write enable, size code, address, write data) and serves it from a word-addressed RAM after a programmable wait.
- Drives the core's PC-enable (PCReady) low to stall the core until the access completes.
- Replaces the zero-wait data memory when multi-cycle memory timing is exercised.

Parameters:
- DEPTH, 2048, number of 32-bit words in RAM; word index = addr[31:2].
- LATENCY, 2, wait cycles before completion; 0 = single-cycle behaviour.
- CNT_W, 4, width of wait counter; must satisfy LATENCY < 2**CNT_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  access request from core (MemStrobe); held stable by core until ready=1.
- we  in  1  write request (MemWrite); meaningful only with req.
- size  in  2  00 word, 01 halfword, 10 byte (loadcontrol encoding); 11 treated as word.
- addr  in  32  byte address (ALUResult).
- wdata  in  32  write data, already lane-positioned by the core.
- rdata  out  32  full word at addr[31:2]; core performs lane select and extension.
- ready  out  1  access complete / core may advance; wired to PCReady.
- err  out  1  misaligned or out-of-range access; valid only when ready=1 and req=1.

Behaviour:
- States: IDLE, BUSY, DONE; wait counter cnt[CNT_W-1:0].
- Reset (reset=0, asynchronous): state=IDLE, cnt=0.
  - ready=0, rdata=0, err=0 while reset is low.
  - RAM contents are not cleared; they are preloaded by $readmemh into array RAM.
- LATENCY=0:
  - FSM stays in IDLE; ready=1 whenever reset is high.
  - rdata is combinational from RAM.
  - Write commits on the rising edge while req&we&~err.
- LATENCY>0, IDLE:
  - ready = ~req (combinational), so non-memory instructions never stall.
  - req=1 → BUSY, cnt=LATENCY-1.
- BUSY:
  - ready=0.
  - cnt decrements each cycle; cnt==0 → DONE.
  - req deasserted in BUSY → IDLE, access aborted, no write.
- DONE:
  - ready=1 for exactly one cycle; rdata and err valid.
  - A write commits on the edge leaving DONE if we=1 and err=0.
  - Next state is IDLE.
  - A new req in the following cycle starts a fresh access, so back-to-back accesses each take LATENCY+1 cycles.
- Byte strobes, derived from size and addr[1:0]:
  - Word: 1111.
  - Half: 0011 when addr[1]=0, 1100 when addr[1]=1.
  - Byte: one-hot at addr[1:0].
  - Only strobed bytes of RAM[addr[31:2]] are updated from the same lanes of wdata; other bytes are unchanged.
- err=1 for any of:
  - word access with addr[1:0]≠00;
  - half access with addr[0]=1;
  - addr[31:2] ≥ DEPTH.
  - On err: no write, rdata=0, completion timing unchanged.
- rdata outside DONE (LATENCY>0) is don't-care; the bench must not check it.
- Reset asserted mid-BUSY or in DONE: immediate return to IDLE with no write; the pending write is lost.
- A read of an address written on the immediately preceding DONE edge returns the new data.

Test Plan:
- LATENCY=2, RAM[25]=0x00000019; req=1 we=0 size=00 addr=0x64 → ready=0 for 2 cycles, then ready=1 one cycle with rdata=0x00000019, err=0.
- RAM[25]=0x11223344; sb: addr=0x65 wdata=0x0000AB00 → after DONE, RAM[25]=0x1122AB44; sh at addr=0x66 wdata=0xBEEF0000 → RAM[25]=0xBEEFAB44.
- Misaligned: sh at addr=0x63, and sw at addr=0x66 → ready pulse with err=1, RAM[25] unchanged. Out-of-range: addr=0x00002000 with DEPTH=2048 → err=1, rdata=0.
- Reset mid-access: sw addr=0x64 wdata=0xDEADBEEF, pull reset low in BUSY → ready=0 and state IDLE immediately; RAM[25] retains its old value; after release, ready=1 with req=0.
- LATENCY=0: run the core's store-then-load program (write 25 to address 100) → ready constantly 1, RAM[25]=0x00000019, no stall cycles.
- Abort and back-to-back (LATENCY=3): drop req in BUSY → IDLE with no write; two consecutive lw requests → ready pulses exactly 4 cycles apart.
